// File: rtl/bit_frame_assembler.sv
// bit_frame_assembler: serial-to-parallel frame assembler for the IR receive path.
// Collects WIDTH bit strobes into one word, in the bit order set by MSB_FIRST, and
// pulses frame_valid when the word is complete. TIMEOUT > 0 adds an inactivity
// watchdog. Optional macro FRAME_CHECK_EN adds a complement check on 32-bit frames
// (address/~address, command/~command); a frame that fails the check is dropped
// and frame_err pulses instead of frame_valid.
module bit_frame_assembler #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic [WIDTH-1:0]           data_out,
    output logic                       frame_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       timeout_err,
    output logic                       frame_err
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, ASSEMBLE = 1'b1} state_t;

    // One-cycle status pulses, registered together.
    typedef struct packed {
        logic fv;
        logic te;
        logic fe;
    } pulse_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_ins;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [CW-1:0]    bit_count_q, bit_count_d, pos;
    pulse_t           pulse_q, pulse_d;
    logic             assembling, capture, last_bit, expire, chk_ok;

    // abort and start outrank a bit strobe in the same cycle, so the strobe only
    // counts when neither is present.
    assign assembling = (state_q == ASSEMBLE);
    assign capture    = assembling && !abort && !start && bit_valid;
    assign last_bit   = capture && (bit_count_q == LAST);
    assign pos        = MSB_FIRST ? (LAST - bit_count_q) : bit_count_q;

    // Shift register with the incoming bit placed at its frame position.
    always_comb begin
        sr_ins = sr_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (pos == CW'(i)) sr_ins[i] = bit_in;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int            WW      = $clog2(TIMEOUT + 1);
            localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
            logic [WW-1:0] wdog_q, wdog_d;

            // Count quiet ASSEMBLE cycles; any strobe, start, abort or IDLE clears it.
            always_comb begin
                wdog_d = wdog_q + 1'b1;
                if (!assembling || abort || start || bit_valid) wdog_d = '0;
            end

            // Watchdog register.
            always_ff @(posedge clk) begin
                if (rst) wdog_q <= '0;
                else     wdog_q <= wdog_d;
            end

            // Expiry loses to a strobe landing in the same cycle.
            assign expire = assembling && !abort && !start && !bit_valid &&
                            (wdog_q == WD_LAST);
        end else begin : g_no_wdog
            assign expire = 1'b0;
        end
    endgenerate

`ifdef FRAME_CHECK_EN
    if (WIDTH != 32) begin : g_width_chk
        $fatal(1, "bit_frame_assembler: FRAME_CHECK_EN requires WIDTH == 32");
    end
    assign chk_ok = (sr_ins[31:24] == ~sr_ins[23:16]) &&
                    (sr_ins[15:8]  == ~sr_ins[7:0]);
`else
    assign chk_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: abort > start > frame completion / watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!abort && start) state_d = ASSEMBLE;
            end
            ASSEMBLE: begin
                if (abort)                   state_d = IDLE;
                else if (start)              state_d = ASSEMBLE;
                else if (last_bit || expire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and pulse outputs for the coming cycle.
    always_comb begin
        sr_d        = sr_q;
        bit_count_d = bit_count_q;
        data_out_d  = data_out_q;
        pulse_d     = '0;
        if (abort) begin
            bit_count_d = '0;
        end else if (start) begin
            sr_d        = '0;
            bit_count_d = '0;
        end else if (capture) begin
            sr_d = sr_ins;
            if (last_bit) begin
                bit_count_d = '0;
                if (chk_ok) begin
                    data_out_d = sr_ins;
                    pulse_d.fv = 1'b1;
                end else begin
                    pulse_d.fe = 1'b1;
                end
            end else begin
                bit_count_d = bit_count_q + 1'b1;
            end
        end else if (expire) begin
            bit_count_d = '0;
            pulse_d.te  = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q        <= '0;
            bit_count_q <= '0;
            data_out_q  <= '0;
            pulse_q     <= '0;
        end else begin
            sr_q        <= sr_d;
            bit_count_q <= bit_count_d;
            data_out_q  <= data_out_d;
            pulse_q     <= pulse_d;
        end
    end

    assign data_out    = data_out_q;
    assign bit_count   = bit_count_q;
    assign busy        = assembling;
    assign frame_valid = pulse_q.fv;
    assign timeout_err = pulse_q.te;
    assign frame_err   = pulse_q.fe;

endmodule

// File: tb/tb_bit_frame_assembler.sv
// Bench for bit_frame_assembler: directed scenarios plus randomized strobes,
// checked every cycle against a frame-level reference model.
// Unit 0: WIDTH=32, MSB first, TIMEOUT=100. Unit 1: WIDTH=8, LSB first, no watchdog
// (only built without FRAME_CHECK_EN, since the check needs WIDTH=32).
module tb_bit_frame_assembler;
    localparam int W0 = 32, TO0 = 100, W1 = 8;
`ifdef FRAME_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] st, ab, bv, bi;

    logic [31:0] d0;
    logic [5:0]  bc0;
    logic        fv0, busy0, te0, fe0;

    bit_frame_assembler #(.WIDTH(W0), .MSB_FIRST(1'b1), .TIMEOUT(TO0)) u_dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .abort(ab[0]), .bit_in(bi[0]),
        .bit_valid(bv[0]), .data_out(d0), .frame_valid(fv0), .busy(busy0),
        .bit_count(bc0), .timeout_err(te0), .frame_err(fe0));

`ifndef FRAME_CHECK_EN
    logic [7:0] d1;
    logic [3:0] bc1;
    logic       fv1, busy1, te1, fe1;

    bit_frame_assembler #(.WIDTH(W1), .MSB_FIRST(1'b0), .TIMEOUT(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .abort(ab[1]), .bit_in(bi[1]),
        .bit_valid(bv[1]), .data_out(d1), .frame_valid(fv1), .busy(busy1),
        .bit_count(bc1), .timeout_err(te1), .frame_err(fe1));
`endif

    always #5 clk = ~clk;

    // Reference model: collected bits per unit, word built only on completion.
    bit          m_bits [2][64];
    int          m_n    [2];
    bit          m_act  [2];
    int          m_quiet[2];
    logic [63:0] m_data [2];
    bit          m_fv[2], m_te[2], m_fe[2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step(input int u, input int w, input bit msb, input int to,
                              input bit fchk);
        logic [63:0] word;
        m_fv[u] = 0; m_te[u] = 0; m_fe[u] = 0;
        if (rst) begin
            m_act[u] = 0; m_n[u] = 0; m_data[u] = '0; m_quiet[u] = 0;
        end else if (ab[u]) begin
            m_act[u] = 0; m_n[u] = 0;
        end else if (st[u]) begin
            m_act[u] = 1; m_n[u] = 0; m_quiet[u] = 0;
        end else if (m_act[u]) begin
            if (bv[u]) begin
                m_bits[u][m_n[u]] = bi[u];
                m_n[u]++;
                m_quiet[u] = 0;
                if (m_n[u] == w) begin
                    word = '0;
                    for (int i = 0; i < w; i++) begin
                        if (msb) word = (word << 1) | 64'(m_bits[u][i]);
                        else     word = word | (64'(m_bits[u][i]) << i);
                    end
                    m_act[u] = 0; m_n[u] = 0;
                    if (fchk && !((word[31:24] == ~word[23:16]) && (word[15:8] == ~word[7:0])))
                        m_fe[u] = 1;
                    else begin
                        m_data[u] = word; m_fv[u] = 1;
                    end
                end
            end else begin
                m_quiet[u]++;
                if (to > 0 && m_quiet[u] == to) begin
                    m_te[u] = 1; m_act[u] = 0; m_n[u] = 0;
                end
            end
        end
    endtask

    // One clock: step the models on the edge's inputs, then compare all outputs.
    task automatic cyc();
        @(posedge clk);
        model_step(0, W0, 1'b1, TO0, FCHK);
        model_step(1, W1, 1'b0, 0, 1'b0);
        #1;
        chk("u0_data",  64'(d0),    m_data[0]);
        chk("u0_fv",    64'(fv0),   64'(m_fv[0]));
        chk("u0_busy",  64'(busy0), 64'(m_act[0]));
        chk("u0_count", 64'(bc0),   64'(m_n[0]));
        chk("u0_tmo",   64'(te0),   64'(m_te[0]));
        chk("u0_ferr",  64'(fe0),   64'(m_fe[0]));
`ifndef FRAME_CHECK_EN
        chk("u1_data",  64'(d1),    m_data[1]);
        chk("u1_fv",    64'(fv1),   64'(m_fv[1]));
        chk("u1_busy",  64'(busy1), 64'(m_act[1]));
        chk("u1_count", 64'(bc1),   64'(m_n[1]));
        chk("u1_tmo",   64'(te1),   64'(m_te[1]));
        chk("u1_ferr",  64'(fe1),   64'(m_fe[1]));
`endif
    endtask

    task automatic open_frame(input int u);
        st[u] = 1'b1; cyc(); st[u] = 1'b0;
    endtask

    // Present the first n bits of word in transmit order, one strobe every gap cycles.
    task automatic send_bits(input int u, input logic [63:0] word, input int w,
                             input bit msb, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            bi[u] = msb ? word[w-1-k] : word[k];
            bv[u] = 1'b1;
            cyc();
            bv[u] = 1'b0;
            if (k != n - 1) repeat (gap - 1) cyc();
        end
    endtask

    initial begin
        int lat;
        int mode;
        rst = 1'b1; st = '0; ab = '0; bv = '0; bi = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_data", 64'(d0), 64'h0);
        chk("reset_busy", 64'(busy0), 64'h0);

        // Basic MSB-first frame, strobe every 4 cycles.
        open_frame(0);
        send_bits(0, 64'h00FF45BA, 32, 1'b1, 32, 4);
        chk("basic_fv",    64'(fv0),   64'h1);
        chk("basic_data",  64'(d0),    64'h00FF45BA);
        chk("basic_busy",  64'(busy0), 64'h0);
        chk("basic_count", 64'(bc0),   64'h0);
        cyc();
        chk("basic_fv_drop", 64'(fv0), 64'h0);

`ifndef FRAME_CHECK_EN
        // LSB-first 8-bit frame: bits 1,0,1,1,0,0,0,0.
        open_frame(1);
        send_bits(1, 64'h0D, 8, 1'b0, 8, 2);
        chk("lsb_fv",   64'(fv1), 64'h1);
        chk("lsb_data", 64'(d1),  64'h0D);
        cyc();
`endif

        // Restart mid-frame (with a strobe in the restart cycle), then abort.
        open_frame(0);
        send_bits(0, 64'hFFFFFFFF, 32, 1'b1, 10, 2);
        st[0] = 1'b1; bv[0] = 1'b1; bi[0] = 1'b1; cyc();
        st[0] = 1'b0; bv[0] = 1'b0;
        chk("restart_count", 64'(bc0), 64'h0);
        send_bits(0, 64'h10EF08F7, 32, 1'b1, 32, 2);
        chk("restart_data", 64'(d0), 64'h10EF08F7);
        cyc();
        open_frame(0);
        send_bits(0, 64'hFFFFFFFF, 32, 1'b1, 5, 2);
        ab[0] = 1'b1; cyc(); ab[0] = 1'b0;
        chk("abort_fv",   64'(fv0),   64'h0);
        chk("abort_busy", 64'(busy0), 64'h0);
        chk("abort_data", 64'(d0),    64'h10EF08F7);
        cyc();

        // Watchdog expiry 100 cycles after the last strobe.
        open_frame(0);
        send_bits(0, 64'hA5A5A5A5, 32, 1'b1, 3, 1);
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (te0) begin lat = i; break; end
        end
        chk("tmo_latency", 64'(lat), 64'd100);
        chk("tmo_busy",    64'(busy0), 64'h0);
        chk("tmo_data",    64'(d0),    64'h10EF08F7);

        // A strobe in the expiry cycle wins over the watchdog.
        open_frame(0);
        send_bits(0, 64'hFFFFFFFF, 32, 1'b1, 1, 1);
        repeat (99) cyc();
        bv[0] = 1'b1; bi[0] = 1'b1; cyc(); bv[0] = 1'b0;
        chk("expiry_strobe_tmo",   64'(te0),   64'h0);
        chk("expiry_strobe_busy",  64'(busy0), 64'h1);
        chk("expiry_strobe_count", 64'(bc0),   64'h2);
        ab[0] = 1'b1; cyc(); ab[0] = 1'b0;

        // Complement check: good frame, then one with a corrupted command byte.
        open_frame(0);
        send_bits(0, 64'h00FF45BA, 32, 1'b1, 32, 1);
        cyc();
        open_frame(0);
        send_bits(0, 64'h00FF45BB, 32, 1'b1, 32, 1);
        if (FCHK) begin
            chk("check_ferr", 64'(fe0), 64'h1);
            chk("check_fv",   64'(fv0), 64'h0);
            chk("check_data", 64'(d0),  64'h00FF45BA);
        end else begin
            chk("nocheck_ferr", 64'(fe0), 64'h0);
            chk("nocheck_fv",   64'(fv0), 64'h1);
            chk("nocheck_data", 64'(d0),  64'h00FF45BB);
        end

        // Back-to-back: start accepted in the frame_valid cycle.
        open_frame(0);
        send_bits(0, 64'h10EF08F7, 32, 1'b1, 32, 1);
        open_frame(0);
        chk("b2b_busy",  64'(busy0), 64'h1);
        chk("b2b_count", 64'(bc0),   64'h0);

        // Reset at bit 20 clears everything.
        send_bits(0, 64'h12345678, 32, 1'b1, 20, 2);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_mid_data",  64'(d0),    64'h0);
        chk("rst_mid_busy",  64'(busy0), 64'h0);
        chk("rst_mid_count", 64'(bc0),   64'h0);
        chk("rst_mid_fv",    64'(fv0),   64'h0);

        // start+strobe in IDLE drops the bit; abort+start ends in IDLE.
        st[0] = 1'b1; bv[0] = 1'b1; bi[0] = 1'b1; cyc();
        st[0] = 1'b0; bv[0] = 1'b0;
        chk("idle_start_count", 64'(bc0),   64'h0);
        chk("idle_start_busy",  64'(busy0), 64'h1);
        st[0] = 1'b1; ab[0] = 1'b1; cyc();
        st[0] = 1'b0; ab[0] = 1'b0;
        chk("abort_start_busy", 64'(busy0), 64'h0);

        // Randomized traffic with dense, sparse and bursty strobe phases.
        mode = 0;
        for (int c = 0; c < 20000; c++) begin
            if (c % 400 == 0) mode = $urandom_range(0, 2);
            rst = ($urandom_range(0, 4999) == 0);
            for (int u = 0; u < 2; u++) begin
                st[u] = ($urandom_range(0, 199) == 0);
                ab[u] = ($urandom_range(0, 399) == 0);
                case (mode)
                    0:       bv[u] = ($urandom_range(0, 1) == 0);
                    1:       bv[u] = ($urandom_range(0, 59) == 0);
                    default: bv[u] = ($urandom_range(0, 3) != 0);
                endcase
                bi[u] = $urandom_range(0, 1);
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
